uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5 to 8.
REQ-002 Parameter PARITY_EN, default 0, meaning a parity bit is inserted after the data bits when set to 1.
REQ-003 Parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, meaning stop-bit count; legal values are 1 or 2.
REQ-005 Port Clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-006 Port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-007 Port Baud_clk, input, 1 bit: square-wave baud clock from the upstream baud generator; treated as asynchronous data.
REQ-008 Port Tx_start, input, 1 bit: one-cycle request to transmit Tx_data.
REQ-009 Port Tx_data, input, DATA_BITS bits: payload, sampled only on acceptance.
REQ-010 Port Tx_ready, output, 1 bit: high when a new Tx_start will be accepted.
REQ-011 Port Tx_busy, output, 1 bit: high from acceptance until frame completion.
REQ-012 Port Tx_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-013 Port Tx_out, output, 1 bit: serial line; idles high.

Function
REQ-014 Baud_clk SHALL pass through a 2-flop synchronizer plus a history flop; bit_tick = sync2 AND NOT history, giving exactly one Clk-cycle pulse per Baud_clk rising edge.
REQ-015 For a given Baud_clk rising edge, any bit_tick-driven output change SHALL occur on the 2nd Clk edge after the Clk edge that first samples Baud_clk=1.
REQ-016 FSM states SHALL be IDLE, ARMED, START, DATA, PARITY and STOP.
REQ-017 IDLE: Tx_ready=1, Tx_busy=0, Tx_out=1.
REQ-018 IDLE with Tx_start=1: latch Tx_data into the shift register, clear the bit counter, go to ARMED; Tx_ready=0 and Tx_busy=1 from the next cycle.
REQ-019 ARMED: Tx_out=1; on bit_tick go to START and drive Tx_out=0.
REQ-020 START, on bit_tick: go to DATA and drive data bit 0 (LSB first).
REQ-021 DATA, on bit_tick: shift out the next bit; after bit DATA_BITS-1 has been held for one tick, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-022 Parity bit SHALL equal XOR of the data bits for even parity, and its inverse for odd parity.
REQ-023 STOP: Tx_out=1 for STOP_BITS ticks; on the tick that ends the last stop bit, go to IDLE and pulse Tx_done for exactly 1 cycle in the same cycle Tx_ready returns to 1.
REQ-024 Every bit SHALL be held from one bit_tick to the next; Tx_out SHALL change only on bit_tick cycles, plus the reset forcing of REQ-029.
REQ-025 Tx_start outside IDLE SHALL be ignored; Tx_data and the frame in flight are unaffected.
REQ-026 Tx_start in the same cycle as Tx_done SHALL be ignored (state is still STOP); a frame is accepted only when Tx_ready=1 at the sampling edge.
REQ-027 If Baud_clk stops toggling, the FSM SHALL hold its state and current Tx_out indefinitely; there is no timeout.
REQ-028 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-029 Reset=0 SHALL asynchronously force: IDLE, Tx_out=1, Tx_ready=1, Tx_busy=0, Tx_done=0, synchronizer and history flops=0, shift register and counters=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no Tx_done; the line returns high immediately.
REQ-031 After Reset deasserts, a Baud_clk already high SHALL produce one bit_tick; it is harmless in IDLE.

Verification
REQ-032 Defaults, Tx_data=8'hA5, single Tx_start -> on successive ticks Tx_out = 0,1,0,1,0,0,1,0,1,1; then Tx_done pulses once; Tx_busy is high for 11 bit_ticks counted from ARMED.
REQ-033 PARITY_EN=1 with PARITY_ODD=0, Tx_data=8'h07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; then STOP_BITS=2 -> 2 high bit periods before Tx_done.
REQ-034 Tx_start pulsed during DATA with Tx_data=8'hFF -> the in-flight frame's bits are unchanged; there is no second frame; Tx_ready stays 0 until Tx_done.
REQ-035 Reset pulsed low during data bit 3 -> Tx_out=1 within the same cycle; Tx_ready=1; no Tx_done; the next Tx_start sends a full, correct frame.
REQ-036 Baud_clk held low for 1000 Clk cycles after acceptance -> state stays ARMED, Tx_out=1, Tx_busy=1; resuming toggling completes a correct frame.
REQ-037 Latency check: the Clk edge that first samples Baud_clk=1 while ARMED is edge N -> Tx_out falls on edge N+2.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit timing is paced by an externally generated, asynchronous square-wave baud clock.
module uart_tx_framer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Baud_clk,
    input  logic                 Tx_start,
    input  logic [DATA_BITS-1:0] Tx_data,
    output logic                 Tx_ready,
    output logic                 Tx_busy,
    output logic                 Tx_done,
    output logic                 Tx_out
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic                 bit_tick_c;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 last_bit_c, last_stop_c;

    // Baud edge detector: two synchronizer stages plus a history flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= Baud_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign bit_tick_c  = sync2_q & ~hist_q;
    // cnt_q counts data bits already driven; it is reused as the stop-bit index in S_STOP.
    assign last_bit_c  = (cnt_q == CNT_W'(DATA_BITS));
    assign last_stop_c = (cnt_q == CNT_W'(STOP_BITS - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Tx_start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bit_tick_c) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_tick_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick_c && last_bit_c) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_tick_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick_c && last_stop_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; the line only moves on bit_tick cycles.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        parity_d   = parity_q;
        tx_out_d   = tx_out_q;
        tx_ready_d = (state_d == S_IDLE);
        tx_busy_d  = (state_d != S_IDLE);
        tx_done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (Tx_start) begin
                    shift_d  = Tx_data;
                    cnt_d    = '0;
                    parity_d = (^Tx_data) ^ (PARITY_ODD != 0);
                end
            end
            S_ARMED: begin
                if (bit_tick_c) begin
                    tx_out_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_tick_c) begin
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    cnt_d    = CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_tick_c) begin
                    if (last_bit_c) begin
                        tx_out_d = (PARITY_EN != 0) ? parity_q : 1'b1;
                        cnt_d    = '0;
                    end else begin
                        tx_out_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick_c) begin
                    tx_out_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_STOP: begin
                if (bit_tick_c) begin
                    tx_out_d = 1'b1;
                    if (!last_stop_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign Tx_out   = tx_out_q;
    assign Tx_ready = tx_ready_q;
    assign Tx_busy  = tx_busy_q;
    assign Tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: default framing, even/odd parity with two stop bits,
// busy-time start rejection, mid-frame reset, baud stall and tick-to-line latency.
module tb_uart_tx_framer;

    logic       Clk      = 1'b0;
    logic       Reset    = 1'b0;
    logic       Baud_clk = 1'b0;
    logic [2:0] start_v  = 3'b000;
    logic [7:0] data     = 8'h00;
    logic [2:0] out_v, ready_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;
    int done_cnt [3] = '{0, 0, 0};

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) done_cnt[k]++;
        end
    end

    // 0: defaults, 1: even parity, 2: odd parity with two stop bits
    uart_tx_framer u_def (
        .Clk(Clk), .Reset(Reset), .Baud_clk(Baud_clk), .Tx_start(start_v[0]), .Tx_data(data),
        .Tx_ready(ready_v[0]), .Tx_busy(busy_v[0]), .Tx_done(done_v[0]), .Tx_out(out_v[0])
    );
    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .Clk(Clk), .Reset(Reset), .Baud_clk(Baud_clk), .Tx_start(start_v[1]), .Tx_data(data),
        .Tx_ready(ready_v[1]), .Tx_busy(busy_v[1]), .Tx_done(done_v[1]), .Tx_out(out_v[1])
    );
    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd (
        .Clk(Clk), .Reset(Reset), .Baud_clk(Baud_clk), .Tx_start(start_v[2]), .Tx_data(data),
        .Tx_ready(ready_v[2]), .Tx_busy(busy_v[2]), .Tx_done(done_v[2]), .Tx_out(out_v[2])
    );

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start_frame(input int inst, input logic [7:0] d);
        start_v[inst] = 1'b1;
        data          = d;
        step(1);
        start_v[inst] = 1'b0;
        data          = 8'h00;
    endtask

    // One baud period; line state sampled late in the high phase, after the tick has landed.
    task automatic do_tick(input int inst, output logic o, output logic b, output logic r);
        Baud_clk = 1'b1;
        step(4);
        o = out_v[inst];
        b = busy_v[inst];
        r = ready_v[inst];
        Baud_clk = 1'b0;
        step(4);
    endtask

    task automatic run_ticks(input int inst, input int nticks, input int inject_after,
                             output logic [15:0] seen, output logic [15:0] busy_seen,
                             output logic [15:0] ready_seen);
        logic o, b, r;
        seen = '0; busy_seen = '0; ready_seen = '0;
        for (int i = 0; i < nticks; i++) begin
            do_tick(inst, o, b, r);
            seen[i] = o; busy_seen[i] = b; ready_seen[i] = r;
            if (i + 1 == inject_after) begin
                start_v[inst] = 1'b1;
                data          = 8'hFF;
                step(1);
                start_v[inst] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        Baud_clk = 1'b1;
        step(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got out/rdy/busy/done=%b expected 1100", k,
                         {out_v[k], ready_v[k], busy_v[k], done_v[k]});
            end
        end
        Reset = 1'b1;
        step(6);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_v[k], ready_v[k], busy_v[k]} !== 3'b110 || done_cnt[k] != 0) begin
                errors++;
                $display("FAIL reset_release_tick inst%0d: got out/rdy/busy=%b done=%0d expected 110 done=0",
                         k, {out_v[k], ready_v[k], busy_v[k]}, done_cnt[k]);
            end
        end
        Baud_clk = 1'b0;
        step(4);
    endtask

    task automatic test_basic_frame();
        logic [15:0] s, b, r;
        int d0 = done_cnt[0];
        start_frame(0, 8'hA5);
        checks++;
        if ({out_v[0], ready_v[0], busy_v[0]} !== 3'b101) begin
            errors++;
            $display("FAIL accept: got out/rdy/busy=%b expected 101", {out_v[0], ready_v[0], busy_v[0]});
        end
        run_ticks(0, 11, 0, s, b, r);
        // start, A5 LSB first, stop, idle
        checks++;
        if (s[10:0] !== 11'h74A) begin
            errors++;
            $display("FAIL basic_bits: got %h expected 74a", s[10:0]);
        end
        checks++;
        if (b[10:0] !== 11'h3FF) begin
            errors++;
            $display("FAIL basic_busy: got %h expected 3ff", b[10:0]);
        end
        checks++;
        if (r[10:0] !== 11'h400) begin
            errors++;
            $display("FAIL basic_ready: got %h expected 400", r[10:0]);
        end
        checks++;
        if (done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulse cycles expected 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_parity();
        logic [15:0] s, b, r;
        int d1 = done_cnt[1];
        int d2 = done_cnt[2];
        start_frame(1, 8'h07);
        run_ticks(1, 12, 0, s, b, r);
        checks++;
        if (s[11:0] !== 12'hE0E) begin
            errors++;
            $display("FAIL even_parity_bits: got %h expected e0e", s[11:0]);
        end
        checks++;
        if (b[11:0] !== 12'h7FF || done_cnt[1] - d1 != 1) begin
            errors++;
            $display("FAIL even_parity_busy_done: got busy=%h done=%0d expected 7ff 1", b[11:0], done_cnt[1] - d1);
        end
        start_frame(2, 8'h07);
        run_ticks(2, 13, 0, s, b, r);
        checks++;
        if (s[12:0] !== 13'h1C0E) begin
            errors++;
            $display("FAIL odd_parity_two_stop_bits: got %h expected 1c0e", s[12:0]);
        end
        checks++;
        if (b[12:0] !== 13'h0FFF || r[12:0] !== 13'h1000) begin
            errors++;
            $display("FAIL two_stop_busy_ready: got busy=%h ready=%h expected 0fff 1000", b[12:0], r[12:0]);
        end
        checks++;
        if (done_cnt[2] - d2 != 1) begin
            errors++;
            $display("FAIL two_stop_done: got %0d expected 1", done_cnt[2] - d2);
        end
    endtask

    task automatic test_ignore_busy_start();
        logic [15:0] s, b, r;
        logic o, bb, rr;
        logic [2:0] extra_out, extra_busy;
        int d0 = done_cnt[0];
        start_frame(0, 8'h3C);
        run_ticks(0, 11, 4, s, b, r);
        checks++;
        if (s[10:0] !== 11'h678) begin
            errors++;
            $display("FAIL ignore_bits: got %h expected 678", s[10:0]);
        end
        checks++;
        if (r[10:0] !== 11'h400) begin
            errors++;
            $display("FAIL ignore_ready: got %h expected 400", r[10:0]);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick(0, o, bb, rr);
            extra_out[i] = o; extra_busy[i] = bb;
        end
        checks++;
        if (extra_out !== 3'b111 || extra_busy !== 3'b000 || done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL ignore_no_second_frame: got out=%b busy=%b done=%0d expected 111 000 1",
                     extra_out, extra_busy, done_cnt[0] - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] s, b, r;
        int d0 = done_cnt[0];
        start_frame(0, 8'hA5);
        run_ticks(0, 5, 0, s, b, r);
        checks++;
        if (s[4:0] !== 5'h0A) begin
            errors++;
            $display("FAIL pre_reset_bits: got %h expected 0a", s[4:0]);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({out_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset_abort: got out/rdy/busy=%b expected 110", {out_v[0], ready_v[0], busy_v[0]});
        end
        step(3);
        Reset = 1'b1;
        step(3);
        checks++;
        if (done_cnt[0] != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d expected %0d", done_cnt[0], d0);
        end
        start_frame(0, 8'h5A);
        run_ticks(0, 11, 0, s, b, r);
        checks++;
        if (s[10:0] !== 11'h6B4 || done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL post_reset_frame: got bits=%h done=%0d expected 6b4 1", s[10:0], done_cnt[0] - d0);
        end
    endtask

    task automatic test_baud_stall();
        logic [15:0] s, b, r;
        int d0 = done_cnt[0];
        start_frame(0, 8'hC3);
        step(1000);
        checks++;
        if ({out_v[0], ready_v[0], busy_v[0]} !== 3'b101) begin
            errors++;
            $display("FAIL stall_hold: got out/rdy/busy=%b expected 101", {out_v[0], ready_v[0], busy_v[0]});
        end
        run_ticks(0, 11, 0, s, b, r);
        checks++;
        if (s[10:0] !== 11'h786 || done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL stall_resume_frame: got bits=%h done=%0d expected 786 1", s[10:0], done_cnt[0] - d0);
        end
    endtask

    task automatic test_latency();
        logic [15:0] s, b, r;
        logic [2:0] line;
        int d0 = done_cnt[0];
        start_frame(0, 8'hA5);
        Baud_clk = 1'b1;
        step(1);
        line[0] = out_v[0];
        step(1);
        line[1] = out_v[0];
        step(1);
        line[2] = out_v[0];
        checks++;
        if (line !== 3'b011) begin
            errors++;
            $display("FAIL start_bit_latency: got line after N,N+1,N+2 = %b (lsb=N) expected 011", line);
        end
        step(2);
        Baud_clk = 1'b0;
        step(4);
        run_ticks(0, 10, 0, s, b, r);
        checks++;
        if (s[9:0] !== 10'h3A5 || done_cnt[0] - d0 != 1) begin
            errors++;
            $display("FAIL latency_frame_rest: got bits=%h done=%0d expected 3a5 1", s[9:0], done_cnt[0] - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_ignore_busy_start();
        test_reset_mid_frame();
        test_baud_stall();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
